raster_coord_stream: RTL

Parametrised raster coordinate source for the fractal/pixel pipeline. Walks a programmable X_SIZE × Y_SIZE grid and emits one signed (x, y) coordinate pair per accepted beat over a valid/ready handshake, row by row, top to bottom. Origin and per-pixel step come from config inputs that are latched at each frame start, which enables pan/zoom. Supports idle/start control, continuous or single-frame mode, synchronous abort, and end-of-row/end-of-frame flags plus a frame counter.

---
 rtl/raster_coord_stream.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/raster_coord_stream.sv
// Raster coordinate source: walks an X_SIZE x Y_SIZE grid row by row and streams signed (x, y)
// pairs over valid/ready. Origin and step are latched at each frame start.
`timescale 1ns/1ps
module raster_coord_stream #(
    parameter int unsigned COORD_W     = 16,
    parameter int unsigned X_SIZE      = 1024,
    parameter int unsigned Y_SIZE      = 1024,
    parameter int unsigned FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic                   continuous,
    input  logic                   abort,
    input  logic [COORD_W-1:0]     cfg_x0,
    input  logic [COORD_W-1:0]     cfg_y0,
    input  logic [COORD_W-1:0]     cfg_dx,
    input  logic [COORD_W-1:0]     cfg_dy,
    input  logic                   ready,
    output logic                   valid,
    output logic [COORD_W-1:0]     x,
    output logic [COORD_W-1:0]     y,
    output logic                   first,
    output logic                   lastx,
    output logic                   lasty,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int unsigned IW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int unsigned JW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [IW-1:0] ILast = IW'(X_SIZE - 1);
    localparam logic [JW-1:0] JLast = JW'(Y_SIZE - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          i_q, i_d;
    logic [JW-1:0]          j_q, j_d;
    logic [COORD_W-1:0]     x_q, x_d;
    logic [COORD_W-1:0]     y_q, y_d;
    logic [COORD_W-1:0]     x0_q, x0_d;
    logic [COORD_W-1:0]     dx_q, dx_d;
    logic [COORD_W-1:0]     dy_q, dy_d;
    logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;

    logic run, at_lastx, at_lasty, load;

    assign run      = (state_q == StRun);
    assign at_lastx = (i_q == ILast);
    assign at_lasty = at_lastx && (j_q == JLast);

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        x_d     = x_q;
        y_d     = y_q;
        x0_d    = x0_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        fcnt_d  = fcnt_q;
        load    = 1'b0;

        if (abort) begin
            state_d = StIdle;
            i_d     = '0;
            j_d     = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (enable) begin
                        load = 1'b1;
                    end
                end
                StRun: begin
                    if (ready) begin
                        if (!at_lastx) begin
                            i_d = i_q + 1'b1;
                            x_d = x_q + dx_q;
                        end else if (!at_lasty) begin
                            // Rows descend: y decreases by dy per row.
                            i_d = '0;
                            j_d = j_q + 1'b1;
                            x_d = x0_q;
                            y_d = y_q - dy_q;
                        end else begin
                            fcnt_d = fcnt_q + 1'b1;
                            if (continuous && enable) begin
                                load = 1'b1;
                            end else begin
                                state_d = StIdle;
                                i_d     = '0;
                                j_d     = '0;
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Frame start: sample config and reload the walk from the origin.
        if (load) begin
            state_d = StRun;
            i_d     = '0;
            j_d     = '0;
            x_d     = cfg_x0;
            y_d     = cfg_y0;
            x0_d    = cfg_x0;
            dx_d    = cfg_dx;
            dy_d    = cfg_dy;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x0_q    <= x0_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign valid     = run;
    assign busy      = run;
    assign x         = x_q;
    assign y         = y_q;
    assign first     = run && (i_q == '0) && (j_q == '0);
    assign lastx     = run && at_lastx;
    assign lasty     = run && at_lasty;
    assign frame_cnt = fcnt_q;

endmodule
